// File: rtl/dbg_gpio_pkg.sv
// Shared constants and types for the debug board-I/O controller:
// command opcodes, reply codes, FSM states and a counter-width helper.
package dbg_gpio_pkg;

    localparam logic [7:0] OP_RD_SW   = 8'h01;
    localparam logic [7:0] OP_RD_EVT  = 8'h02;
    localparam logic [7:0] OP_WR_LED  = 8'h03;
    localparam logic [7:0] OP_RD_LED  = 8'h04;
    localparam logic [7:0] OP_RD_STAT = 8'h05;

    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ARG = 2'd1,
        RESP     = 2'd2
    } state_t;

    // Bits needed for a counter that runs from 0 to n-1.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dbg_gpio_uart_ctrl_if.sv
// UART byte-stream link between the host-side UART and the I/O controller.
interface dbg_gpio_uart_ctrl_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output rx_data, rx_valid, tx_ready,
        input  tx_data, tx_valid
    );

    modport slave (
        input  rx_data, rx_valid, tx_ready,
        output tx_data, tx_valid
    );
endinterface

// File: rtl/dbg_debounce.sv
// Per-bit 2-flop synchroniser followed by a hold-time debounce counter;
// a new level is accepted only after it has been seen for DEB_CYCLES cycles.
module dbg_debounce
    import dbg_gpio_pkg::*;
#(
    parameter int WIDTH      = 1,
    parameter int DEB_CYCLES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] raw_i,
    output logic [WIDTH-1:0] stable_o
);
    localparam int            CW       = cnt_width(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic [WIDTH-1:0] sync1_r;
    logic [WIDTH-1:0] sync2_r;
    logic [WIDTH-1:0] stable_r;
    logic [CW-1:0]    cnt_r [WIDTH];

    // Synchronise the asynchronous raw inputs into the clock domain.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_r <= '0;
            sync2_r <= '0;
        end else begin
            sync1_r <= raw_i;
            sync2_r <= sync1_r;
        end
    end

    // Count how long each synced bit differs from its accepted level; any agreement restarts it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stable_r <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync2_r[i] != stable_r[i]) begin
                    if (cnt_r[i] == CNT_LAST) begin
                        stable_r[i] <= sync2_r[i];
                        cnt_r[i]    <= '0;
                    end else begin
                        cnt_r[i] <= cnt_r[i] + CW'(1);
                    end
                end else begin
                    cnt_r[i] <= '0;
                end
            end
        end
    end

    assign stable_o = stable_r;
endmodule

// File: rtl/dbg_gpio_uart_ctrl.sv
// Debounced buttons/switches, button-press event capture and an LED register,
// all exposed to the host through a one-opcode / optional-argument byte protocol.
module dbg_gpio_uart_ctrl
    import dbg_gpio_pkg::*;
#(
    parameter int N_BTN       = 4,
    parameter int N_SW        = 8,
    parameter int N_LED       = 7,
    parameter int DEB_CYCLES  = 250000,
    parameter int ARG_TIMEOUT = 2500000
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [N_BTN-1:0]     btn_i,
    input  logic [N_SW-1:0]      sw_i,
    dbg_gpio_uart_ctrl_if.slave  uart,
    output logic [N_LED-1:0]     led_o,
    output logic [N_BTN-1:0]     btn_o,
    output logic [N_SW-1:0]      sw_o,
    output logic                 busy_o,
    output logic                 overrun_o
);
    localparam int            TW       = cnt_width(ARG_TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(ARG_TIMEOUT - 1);

    state_t           state_r;
    logic [TW-1:0]    tmo_r;
    logic [7:0]       tx_data_r;
    logic             tx_valid_r;
    logic [N_LED-1:0] led_r;
    logic             busy_r;
    logic [N_BTN-1:0] btn_prev_r;
    logic [N_BTN-1:0] evt_r;
    logic             ovr_r;

    logic [N_BTN-1:0] rise_s;
    logic [N_BTN-1:0] evt_clr_s;
    logic             ovr_clr_s;
    logic             ovr_set_s;
    logic [7:0]       sw_ext_s;
    logic [7:0]       evt_ext_s;
    logic [7:0]       led_ext_s;
    logic [7:0]       reply_s;

    dbg_debounce #(.WIDTH(N_BTN), .DEB_CYCLES(DEB_CYCLES)) u_btn_deb (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .raw_i    (btn_i),
        .stable_o (btn_o)
    );

    dbg_debounce #(.WIDTH(N_SW), .DEB_CYCLES(DEB_CYCLES)) u_sw_deb (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .raw_i    (sw_i),
        .stable_o (sw_o)
    );

    // Zero-extend the readable registers to a reply byte.
    always_comb begin
        sw_ext_s  = 8'h00;
        evt_ext_s = 8'h00;
        led_ext_s = 8'h00;
        sw_ext_s[N_SW-1:0]   = sw_o;
        evt_ext_s[N_BTN-1:0] = evt_r;
        led_ext_s[N_LED-1:0] = led_r;
    end

    // Reply byte for an opcode received in IDLE.
    always_comb begin
        reply_s = NAK;
        case (uart.rx_data)
            OP_RD_SW:   reply_s = sw_ext_s;
            OP_RD_EVT:  reply_s = evt_ext_s;
            OP_RD_LED:  reply_s = led_ext_s;
            OP_RD_STAT: reply_s = {6'b000000, |evt_r, ovr_r};
            default:    reply_s = NAK;
        endcase
    end

    // Clear requests are issued when the reply is loaded; new sets still win afterwards.
    always_comb begin
        rise_s    = btn_o & ~btn_prev_r;
        ovr_set_s = (state_r == RESP) && uart.rx_valid;
        if ((state_r == IDLE) && uart.rx_valid) begin
            evt_clr_s = (uart.rx_data == OP_RD_EVT) ? evt_r : '0;
            ovr_clr_s = (uart.rx_data == OP_RD_STAT);
        end else begin
            evt_clr_s = '0;
            ovr_clr_s = 1'b0;
        end
    end

    // Button-press event capture and sticky overrun flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            btn_prev_r <= '0;
            evt_r      <= '0;
            ovr_r      <= 1'b0;
        end else begin
            btn_prev_r <= btn_o;
            evt_r      <= (evt_r & ~evt_clr_s) | rise_s;
            ovr_r      <= (ovr_r & ~ovr_clr_s) | ovr_set_s;
        end
    end

    // Command FSM with registered reply, LED register and busy flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r    <= IDLE;
            tmo_r      <= '0;
            tx_data_r  <= 8'h00;
            tx_valid_r <= 1'b0;
            led_r      <= '0;
            busy_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (uart.rx_valid) begin
                        busy_r <= 1'b1;
                        if (uart.rx_data == OP_WR_LED) begin
                            state_r <= WAIT_ARG;
                            tmo_r   <= '0;
                        end else begin
                            tx_data_r  <= reply_s;
                            tx_valid_r <= 1'b1;
                            state_r    <= RESP;
                        end
                    end
                end
                WAIT_ARG: begin
                    if (uart.rx_valid) begin
                        led_r      <= uart.rx_data[N_LED-1:0];
                        tx_data_r  <= ACK;
                        tx_valid_r <= 1'b1;
                        state_r    <= RESP;
                    end else if (tmo_r == TMO_LAST) begin
                        tx_data_r  <= NAK;
                        tx_valid_r <= 1'b1;
                        state_r    <= RESP;
                    end else begin
                        tmo_r <= tmo_r + TW'(1);
                    end
                end
                RESP: begin
                    if (uart.tx_ready) begin
                        tx_valid_r <= 1'b0;
                        busy_r     <= 1'b0;
                        state_r    <= IDLE;
                    end
                end
                default: begin
                    tx_valid_r <= 1'b0;
                    busy_r     <= 1'b0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

    assign uart.tx_data  = tx_data_r;
    assign uart.tx_valid = tx_valid_r;
    assign led_o         = led_r;
    assign busy_o        = busy_r;
    assign overrun_o     = ovr_r;
endmodule

// File: tb/tb_dbg_gpio_uart_ctrl.sv
// Scoreboard bench: commands push their expected reply, a monitor pops on each TX handshake.
module tb_dbg_gpio_uart_ctrl;
    localparam int N_BTN = 4;
    localparam int N_SW  = 8;
    localparam int N_LED = 7;

    logic             clk = 1'b0;
    logic             rst;
    logic [N_BTN-1:0] btn;
    logic [N_SW-1:0]  sw;
    logic [N_LED-1:0] led;
    logic [N_BTN-1:0] btn_d;
    logic [N_SW-1:0]  sw_d;
    logic             busy;
    logic             ovr;

    dbg_gpio_uart_ctrl_if uart ();

    dbg_gpio_uart_ctrl #(
        .N_BTN(N_BTN), .N_SW(N_SW), .N_LED(N_LED),
        .DEB_CYCLES(4), .ARG_TIMEOUT(16)
    ) dut (
        .clk_i(clk), .rst_i(rst), .btn_i(btn), .sw_i(sw), .uart(uart),
        .led_o(led), .btn_o(btn_d), .sw_o(sw_d), .busy_o(busy), .overrun_o(ovr)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    bit         hold_ready = 1'b0;

    // Reference model state
    logic [7:0]       m_sw  = 8'h00;
    logic [N_BTN-1:0] m_evt = '0;
    logic [N_LED-1:0] m_led = '0;
    logic             m_ovr = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every TX handshake must match the oldest expected reply.
    always @(negedge clk) begin
        if (rst === 1'b0 && uart.tx_valid === 1'b1 && uart.tx_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_reply: got 0x%0h expected none", uart.tx_data);
            end else begin
                check("reply", {24'h0, uart.tx_data}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    // Random TX backpressure unless held off.
    initial begin
        uart.tx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            uart.tx_ready = hold_ready ? 1'b0 : 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        uart.rx_data  = b;
        uart.rx_valid = 1'b1;
        tick(1);
        uart.rx_valid = 1'b0;
        uart.rx_data  = 8'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            tick(1);
            n++;
        end
        check("idle_timeout", {31'h0, busy}, 32'h0);
    endtask

    task automatic cmd(input logic [7:0] op);
        logic [7:0] e;
        case (op)
            8'h01: e = m_sw;
            8'h02: begin e = 8'(m_evt); m_evt = '0; end
            8'h04: e = 8'(m_led);
            8'h05: begin e = {6'h0, m_evt != '0, m_ovr}; m_ovr = 1'b0; end
            default: e = 8'h15;
        endcase
        exp_q.push_back(e);
        send_byte(op);
        check("tx_valid_latency", {31'h0, uart.tx_valid}, 32'h1);
        wait_idle();
    endtask

    task automatic wr_led(input logic [7:0] arg);
        send_byte(8'h03);
        check("wait_arg_busy", {30'h0, busy, uart.tx_valid}, 32'h2);
        exp_q.push_back(8'h06);
        send_byte(arg);
        m_led = arg[N_LED-1:0];
        check("ack_latency", {31'h0, uart.tx_valid}, 32'h1);
        check("led_write", {25'h0, led}, {25'h0, m_led});
        wait_idle();
    endtask

    task automatic set_sw(input logic [7:0] v);
        sw = v;
        tick(8);
        m_sw = v;
    endtask

    task automatic press(input int i);
        btn[i] = 1'b1;
        tick(10);
        m_evt[i] = 1'b1;
        btn[i] = 1'b0;
        tick(10);
    endtask

    initial begin
        int n;
        logic [7:0] ops [4];
        ops[0] = 8'h01; ops[1] = 8'h02; ops[2] = 8'h04; ops[3] = 8'h05;
        rst = 1'b1;
        btn = '0;
        sw  = '0;
        uart.rx_valid = 1'b0;
        uart.rx_data  = 8'h00;
        tick(3);
        check("reset_outputs", {8'h0, led, btn_d, sw_d, busy, ovr},  32'h0);
        check("reset_tx", {23'h0, uart.tx_valid, uart.tx_data}, 32'h0);
        rst = 1'b0;
        tick(2);

        // Switch debounce latency and read-back
        sw = 8'hA5;
        tick(5);
        check("sw_early", {24'h0, sw_d}, 32'h0);
        tick(1);
        check("sw_latency", {24'h0, sw_d}, 32'hA5);
        m_sw = 8'hA5;
        cmd(8'h01);

        // Short glitch ignored, held press captured once
        btn[2] = 1'b1;
        tick(3);
        btn[2] = 1'b0;
        tick(10);
        check("btn_glitch", {28'h0, btn_d}, 32'h0);
        cmd(8'h02);
        btn[2] = 1'b1;
        tick(10);
        check("btn_held", {28'h0, btn_d}, 32'h4);
        m_evt[2] = 1'b1;
        cmd(8'h02);
        cmd(8'h02);
        btn[2] = 1'b0;
        tick(10);

        // LED write and read-back
        wr_led(8'h5A);
        cmd(8'h04);

        // Argument timeout gives NAK and leaves LEDs alone
        exp_q.push_back(8'h15);
        send_byte(8'h03);
        n = 0;
        while (!uart.tx_valid && n < 40) begin
            tick(1);
            n++;
        end
        check("timeout_cycles", n, 16);
        check("timeout_led", {25'h0, led}, {25'h0, m_led});
        wait_idle();

        // Overrun on a byte received during RESP
        hold_ready = 1'b1;
        tick(2);
        exp_q.push_back(m_sw);
        send_byte(8'h01);
        send_byte(8'h7F);
        m_ovr = 1'b1;
        check("overrun_set", {31'h0, ovr}, 32'h1);
        tick(3);
        hold_ready = 1'b0;
        wait_idle();
        cmd(8'h05);
        check("overrun_clear", {31'h0, ovr}, 32'h0);
        cmd(8'h7F);

        // Randomised traffic against the model
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 9))
                0:       set_sw(8'($urandom));
                1:       press(int'($urandom_range(0, N_BTN - 1)));
                2:       wr_led(8'($urandom));
                9:       cmd(8'($urandom_range(6, 255)));
                default: cmd(ops[$urandom_range(0, 3)]);
            endcase
        end

        // Reset in the middle of WAIT_ARG
        wr_led(8'h3C);
        send_byte(8'h03);
        tick(3);
        rst = 1'b1;
        #1;
        check("midrst_outputs", {8'h0, led, btn_d, sw_d, busy, ovr}, 32'h0);
        check("midrst_tx", {23'h0, uart.tx_valid, uart.tx_data}, 32'h0);
        tick(2);
        rst = 1'b0;
        m_led = '0;
        m_evt = '0;
        m_ovr = 1'b0;
        tick(30);
        check("post_rst_idle", {30'h0, busy, uart.tx_valid}, 32'h0);
        cmd(8'h04);
        cmd(8'h01);
        check("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dbg_gpio_uart_ctrl.md
Name: dbg_gpio_uart_ctrl

Overview:
Parametrised board-I/O controller for the FPGA debugger top. It debounces N_BTN push-buttons and N_SW switches, latches button-press events, and holds an N_LED output register. It serves a byte-level command protocol from the UART RX byte stream and replies on the UART TX byte interface. It replaces the bare button/switch/LED pins at the top level with host-visible, debounced, event-capturing I/O.

Parameters:
N_BTN, 4, push-button count (1..8)
N_SW, 8, switch count (1..8)
N_LED, 7, LED count (1..8)
DEB_CYCLES, 250000, cycles an input must hold a new level before it is accepted (10 ms at 25 MHz); minimum 2
ARG_TIMEOUT, 2500000, cycles to wait for a command argument byte before abort

Ports:
clk_i  in  1  single system clock
rst_i  in  1  reset, asynchronous, active-high
btn_i  in  N_BTN  raw push-buttons, active-high, asynchronous
sw_i  in  N_SW  raw switches, asynchronous
rx_data_i  in  8  received UART byte
rx_valid_i  in  1  one-cycle strobe, rx_data_i valid; no backpressure
tx_data_o  out  8  reply byte
tx_valid_o  out  1  reply valid
tx_ready_i  in  1  UART TX accepts the byte when valid&ready
led_o  out  N_LED  LED register
btn_o  out  N_BTN  debounced buttons
sw_o  out  N_SW  debounced switches
busy_o  out  1  high whenever FSM is not IDLE
overrun_o  out  1  sticky: an RX byte was dropped

Behaviour:
- Reset (async assert, sync release): led_o=0, btn_o=0, sw_o=0, event register=0, tx_valid_o=0, tx_data_o=0, overrun_o=0, busy_o=0, FSM=IDLE, all counters=0.
- Input path, per bit: 2-flop synchroniser, then debounce counter. If synced!=stable, counter increments. When the counter reaches DEB_CYCLES-1 with synced still different, stable<=synced and counter<=0. Any cycle with synced==stable clears the counter, so a glitch restarts the count. Latency from a clean raw edge to the output = 2 + DEB_CYCLES cycles.
- Event register evt[N_BTN]: bit set on a 0->1 transition of debounced btn. A set in the same cycle as a clear wins, so no event is lost.
- Commands: first byte is the opcode. Reply values are zero-extended to 8 bits.
  - 0x01 RD_SW: reply sw_o.
  - 0x02 RD_EVT: reply evt, then clear only the bits reported (evt &= ~reported), at the cycle the reply is captured.
  - 0x03 WR_LED: wait for an argument byte; led_o<=arg[N_LED-1:0] in the cycle after arg receipt; reply 0x06 ACK.
  - 0x04 RD_LED: reply led_o.
  - 0x05 RD_STAT: reply {6'b0, |evt, overrun_o}, then clear overrun_o. A concurrent new overrun wins.
  - Any other opcode: reply 0x15 NAK.
- FSM states:
  - IDLE: on rx_valid_i, decode the opcode. WR_LED goes to WAIT_ARG; all others load tx_data_o and go to RESP.
  - WAIT_ARG: timeout counter runs. On rx_valid_i, apply the LED write, load ACK, go to RESP. If the counter reaches ARG_TIMEOUT-1, load NAK and go to RESP; LEDs are unchanged.
  - RESP: tx_valid_o=1 and tx_data_o held stable until tx_ready_i. On handshake, go to IDLE with tx_valid_o=0.
- Reply timing: tx_valid_o rises the cycle after the opcode (or argument) strobe.
- Any rx_valid_i in RESP is dropped and sets overrun_o. A byte arriving in the same cycle as the RESP handshake is also dropped.
- busy_o = (state!=IDLE), registered with the state.
- Reset asserted mid-transaction aborts immediately to the reset values. A pending reply is discarded.

Decomposition:
- Shared package dbg_gpio_pkg: opcode constants (OP_RD_SW, OP_RD_EVT, OP_WR_LED, OP_RD_LED, OP_RD_STAT), ACK=0x06, NAK=0x15, FSM state enum (IDLE, WAIT_ARG, RESP), and a clog2-based counter-width function.
- One sub-module, dbg_debounce (WIDTH, DEB_CYCLES): synchroniser plus per-bit counter. Instantiated twice, once for buttons and once for switches.

Test Plan:
- DEB_CYCLES=4. Raw sw_i=0xA5 held -> sw_o=0xA5 exactly 6 cycles later. Then send opcode 0x01 -> tx byte 0xA5, tx_valid_o 1 cycle after the strobe.
- DEB_CYCLES=4. btn_i[2] pulses high for 3 cycles -> btn_o unchanged, evt=0. Holding it high for 10 cycles, then sending 0x02 -> reply 0x04. A second 0x02 -> reply 0x00.
- Send 0x03 then 0x5A (N_LED=7) -> led_o=0x5A, reply 0x06. Then 0x04 -> reply 0x5A.
- ARG_TIMEOUT=16. Send 0x03 and no argument -> NAK 0x15 after 16 cycles in WAIT_ARG; led_o unchanged.
- Hold tx_ready_i=0 in RESP and inject an RX byte -> byte dropped, overrun_o=1. Then 0x05 -> reply 0x01 and overrun_o clears. Unknown opcode 0x7F -> 0x15.
- Assert rst_i while in WAIT_ARG with led_o=0x3C -> all outputs 0 immediately, FSM IDLE, no reply emitted after release.
